// File: rtl/down_timer_nbit.sv
// down_timer_nbit: loadable N-bit down-counting timer with run/pause control
// and a registered terminal-count pulse (min_tick).
// Optional feature macro: AUTO_RELOAD_EN. When it is defined, the timer
// reloads itself from reload_reg after reaching zero instead of stopping in
// DONE, which makes it periodic.
module down_timer_nbit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         start,
    input  logic         pause,
    input  logic         en_tick,
    output logic [N-1:0] y,
    output logic         min_tick,
    output logic         busy,
    output logic         done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [N-1:0] ZERO = '0;
    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]   state;
    logic [N-1:0] reload_reg;

    // start only acts when pause is low, since pause outranks start
    logic go;
    assign go = start & ~pause;

    // Counter, reload register, FSM and terminal pulse, all registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            y          <= ZERO;
            reload_reg <= ZERO;
            state      <= IDLE;
            min_tick   <= 1'b0;
        end else begin
            min_tick <= 1'b0;
            if (load) begin
                // load aborts any count in progress
                y          <= load_val;
                reload_reg <= load_val;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (go) begin
                            if (y != ZERO) begin
                                state <= RUN;
                            end else begin
                                state    <= DONE;
                                min_tick <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state <= PAUSE;
                        end else if (en_tick) begin
                            if (y > ONE) begin
                                y <= y - ONE;
                            end else if (y == ONE) begin
                                y        <= ZERO;
                                min_tick <= 1'b1;
`ifdef AUTO_RELOAD_EN
                                // periodic mode only stops when there is nothing to reload
                                state <= (reload_reg == ZERO) ? DONE : RUN;
`else
                                state <= DONE;
`endif
                            end
`ifdef AUTO_RELOAD_EN
                            else begin
                                // y==0 here only in periodic mode: start the next period
                                y <= reload_reg;
                            end
`endif
                        end
                    end
                    PAUSE: begin
                        if (go) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                        // DONE
                        if (go) begin
                            if (reload_reg != ZERO) begin
                                y     <= reload_reg;
                                state <= RUN;
                            end else begin
                                // toggling keeps a held start from merging pulses
                                min_tick <= ~min_tick;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Status decoded from the registered state only.
    assign busy = (state == RUN) || (state == PAUSE);
    assign done = (state == DONE);

endmodule
